// File: rtl/serial_mmio_port_pkg.sv
// Shared definitions for the serial MMIO port: register map, status layout and TX FSM states.
package serial_mmio_port_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int unsigned ST_RX_AVAIL  = 0;
  localparam int unsigned ST_TX_READY  = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned BUSY_TIMEOUT = 16;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_DRAIN     = 2'd3
  } tx_state_e;

endpackage

// File: rtl/serial_mmio_port_rx_fifo.sv
// Byte FIFO with first-word-fall-through head; a pop frees a slot for a simultaneous push.
module serial_rx_fifo
  import serial_mmio_port_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [7:0]            din_i,
  output logic [7:0]            head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o    = (count_q == '0);
  // Count never exceeds DEPTH, so its MSB alone flags full.
  assign full_o     = count_q[DEPTH_LOG2];
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & full_o & ~do_pop;
  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_mmio_port.sv
// CPU-side serial window: buffered RX with status register, single-byte TX holding register and start sequencer.
module serial_mmio_port
  import serial_mmio_port_pkg::*;
#(
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned START_HOLD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i
);

  localparam int unsigned CNT_W = 5;

  logic                   rx_ready_q;
  logic                   overrun_q;
  logic                   overrun_d;
  logic [7:0]             hold_q;
  logic                   hold_valid_q;
  logic [7:0]             tx_data_q;
  logic                   tx_start_q;
  logic [CNT_W-1:0]       cnt_q;
  tx_state_e              state_q;

  logic                   rx_push;
  logic                   rd_data;
  logic                   rd_status;
  logic                   wr_data;
  logic                   wr_accept;
  logic [7:0]             rx_head;
  logic                   rx_full;
  logic                   rx_empty;
  logic                   rx_overflow;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic [31:0]            status_word;
  logic                   unused_data_hi;

  assign rx_push   = rx_ready_i & ~rx_ready_q;
  assign rd_data   = ce_i & ~we_i & (addr_i == REG_DATA);
  assign rd_status = ce_i & ~we_i & (addr_i == REG_STATUS);
  assign wr_data   = ce_i & we_i & (addr_i == REG_DATA);
  assign wr_accept = wr_data & ~hold_valid_q;
  assign stall_o   = wr_data & hold_valid_q;
  assign unused_data_hi = ^data_i[31:8];

  serial_rx_fifo #(
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rx_push),
    .pop_i      (rd_data),
    .din_i      (rx_data_i),
    .head_o     (rx_head),
    .full_o     (rx_full),
    .empty_o    (rx_empty),
    .overflow_o (rx_overflow),
    .count_o    (rx_count)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_COUNT_LSB +: 8] = 8'(rx_count);
    status_word[ST_OVERRUN]        = overrun_q;
    status_word[ST_TX_READY]       = ~hold_valid_q;
    status_word[ST_RX_AVAIL]       = ~rx_empty;
  end

  always_comb begin
    data_o = '0;
    if (rd_data && !rx_empty) begin
      data_o = {24'b0, rx_head};
    end else if (rd_status) begin
      data_o = status_word;
    end
  end

  // A fresh overrun in the same cycle as a STATUS read must survive the clear.
  assign overrun_d = rx_overflow | (overrun_q & ~rd_status);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready_i;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      if (wr_accept) begin
        hold_q       <= data_i[7:0];
        hold_valid_q <= 1'b1;
      end
      unique case (state_q)
        TX_IDLE: begin
          if (hold_valid_q) begin
            tx_data_q    <= hold_q;
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
            tx_start_q   <= 1'b1;
            state_q      <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_q == CNT_W'(START_HOLD - 1)) begin
            tx_start_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= TX_WAIT_BUSY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_WAIT_BUSY: begin
          if (tx_busy_i || cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
            state_q <= TX_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_DRAIN: begin
          if (!tx_busy_i) begin
            state_q <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;

endmodule

// File: tb/tb_serial_mmio_port.sv
// Scoreboard bench for serial_mmio_port: read and TX expectations are queued by stimulus, checked by monitors.
module tb_serial_mmio_port;

  localparam int unsigned RXL   = 4;
  localparam int unsigned SHOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic        addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic [7:0]  rx_data_i;
  logic        rx_ready_i;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_busy_i = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  string       rd_nm_q [$];
  logic [31:0] rd_exp_q [$];
  logic [7:0]  tx_q [$];

  bit   busy_en = 1'b0;
  int   rise_cnt = 0;
  int   last_rise_cyc = 0;
  int   prev_rise_cyc = 0;
  logic start_prev = 1'b0;
  int   start_w = 0;
  logic [7:0] cur_byte = '0;
  bit   byte_stable = 1'b1;

  serial_mmio_port #(
    .RX_DEPTH_LOG2 (RXL),
    .START_HOLD    (SHOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .rx_data_i  (rx_data_i),
    .rx_ready_i (rx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_start_o (tx_start_o),
    .tx_busy_i  (tx_busy_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
  endtask

  // Read monitor: every read cycle consumes one queued expectation.
  always @(negedge clk) begin
    if (!rst && ce_i && !we_i) begin
      chk("rd_no_stall", 32'(stall_o), 32'd0);
      if (rd_exp_q.size() == 0) begin
        chk("rd_unexpected", data_o, 32'hDEAD_BEEF);
      end else begin
        chk(rd_nm_q.pop_front(), data_o, rd_exp_q.pop_front());
      end
    end
  end

  // TX monitor: byte order, pulse width and data stability while start is high.
  always @(negedge clk) begin
    if (rst) begin
      start_prev = 1'b0;
      start_w    = 0;
    end else begin
      if (tx_start_o && !start_prev) begin
        rise_cnt++;
        prev_rise_cyc = last_rise_cyc;
        last_rise_cyc = cyc;
        cur_byte      = tx_data_o;
        byte_stable   = 1'b1;
        start_w       = 1;
        if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_data_o), 32'hDEAD_BEEF);
        else chk("tx_byte", 32'(tx_data_o), 32'(tx_q.pop_front()));
      end else if (tx_start_o) begin
        start_w++;
        if (tx_data_o !== cur_byte) byte_stable = 1'b0;
      end else if (start_prev) begin
        chk("tx_start_width", 32'(start_w), 32'(SHOLD));
        chk("tx_data_stable", 32'(byte_stable), 32'd1);
      end
      start_prev = tx_start_o;
    end
  end

  // Transmitter model: busy for 20 cycles starting 2 cycles after each start rise.
  always begin
    @(posedge tx_start_o);
    if (busy_en) begin
      repeat (2) @(posedge clk);
      #1 tx_busy_i = 1'b1;
      repeat (20) @(posedge clk);
      #1 tx_busy_i = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_read(input logic a, input logic [31:0] exp, input string nm);
    rd_nm_q.push_back(nm);
    rd_exp_q.push_back(exp);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a;
    step();
    ce_i = 1'b0;
  endtask

  task automatic mmio_write(input logic a, input logic [7:0] d, input int exp_stall_first,
                            output int stalls, output int acc_cyc);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = {24'hABCDEF, d};
    stalls = 0; acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0 && exp_stall_first >= 0) chk("wr_first_stall", 32'(stall_o), 32'(exp_stall_first));
      if (!stall_o) begin
        acc_cyc = cyc;
        if (a == 1'b0) tx_q.push_back(d);
        step();
        break;
      end
      stalls++;
      step();
    end
    ce_i = 1'b0; we_i = 1'b0;
    if (acc_cyc < 0) chk("wr_timeout", 32'(stalls), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data_i = b; rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
    step();
  endtask

  task automatic wait_rises(input int target, input int budget, input string nm);
    int i = 0;
    while (rise_cnt < target && i < budget) begin
      step();
      i++;
    end
    if (rise_cnt < target) chk(nm, 32'(rise_cnt), 32'(target));
  endtask

  initial begin
    int s, acc, s77, acc77, base;
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = 1'b0; data_i = '0;
    rx_data_i = '0; rx_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_tx_start", 32'(tx_start_o), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Three bytes in, read back in order.
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    mmio_read(1'b1, 32'h0000_0303, "status_3");
    mmio_read(1'b0, 32'h41, "rd_41");
    mmio_read(1'b0, 32'h42, "rd_42");
    mmio_read(1'b0, 32'h43, "rd_43");
    mmio_read(1'b1, 32'h0000_0002, "status_empty");

    // Overrun on the 17th byte.
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    mmio_read(1'b1, 32'h0000_1007, "status_overrun");
    mmio_read(1'b1, 32'h0000_1003, "status_overrun_clr");
    mmio_read(1'b0, 32'h00, "rd_byte0");
    mmio_read(1'b1, 32'h0000_0F03, "status_15");
    for (int i = 1; i < 16; i++) mmio_read(1'b0, 32'(i), "rd_drain");
    mmio_read(1'b0, 32'h0, "rd_empty");
    mmio_read(1'b1, 32'h0000_0002, "status_empty2");

    // Held-high ready pushes once; push+pop on a full FIFO.
    rx_data_i = 8'hA0; rx_ready_i = 1'b1;
    repeat (10) step();
    rx_ready_i = 1'b0;
    step();
    mmio_read(1'b1, 32'h0000_0103, "status_held_ready");
    for (int i = 1; i < 16; i++) push_byte(8'hB0 + 8'(i));
    rx_data_i = 8'hC0; rx_ready_i = 1'b1;
    mmio_read(1'b0, 32'hA0, "rd_push_pop_full");
    rx_ready_i = 1'b0;
    step();
    mmio_read(1'b1, 32'h0000_1003, "status_push_pop_full");
    for (int i = 1; i < 16; i++) mmio_read(1'b0, 32'hB0 + 32'(i), "rd_drain_b");
    mmio_read(1'b0, 32'hC0, "rd_c0");

    // Back-to-back TX with transmitter busy model.
    busy_en = 1'b1;
    base = rise_cnt;
    mmio_write(1'b1, 8'hEE, 0, s, acc);
    mmio_write(1'b0, 8'h55, 0, s, acc);
    mmio_write(1'b0, 8'h66, 1, s, acc);
    mmio_write(1'b0, 8'h77, -1, s77, acc77);
    chk("b2b_77_stalled", 32'(s77 > 0), 32'd1);
    chk("b2b_77_accept_cycle", 32'(acc77), 32'(last_rise_cyc));
    wait_rises(base + 3, 200, "b2b_rise_timeout");
    repeat (35) step();
    chk("b2b_tx_q_empty", 32'(tx_q.size()), 32'd0);
    busy_en = 1'b0;

    // Reset in START drops start at once and loses the pending byte.
    base = rise_cnt;
    mmio_write(1'b0, 8'hA5, 0, s, acc);
    wait_rises(base + 1, 20, "rst_rise_timeout");
    mmio_write(1'b0, 8'h5A, 0, s, acc);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx_start", 32'(tx_start_o), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data_o), 32'd0);
    step();
    rst = 1'b0;
    tx_q.delete();
    step();
    mmio_read(1'b1, 32'h0000_0002, "status_after_rst");
    repeat (15) step();
    chk("rst_hold_lost", 32'(rise_cnt), 32'(base + 1));

    // Busy never rises: timeout path spaces start rises 22 cycles apart.
    base = rise_cnt;
    mmio_write(1'b0, 8'h11, 0, s, acc);
    wait_rises(base + 1, 20, "to_rise1_timeout");
    mmio_write(1'b0, 8'h22, 0, s, acc);
    wait_rises(base + 2, 100, "to_rise2_timeout");
    chk("timeout_rise_gap", 32'(last_rise_cyc - prev_rise_cyc), 32'd22);
    repeat (30) step();
    chk("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
